// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive FIFO.
// Holds the capture FSM encoding and the default sizing constants.
package uart_pkg;

  localparam int DEFAULT_DEPTH  = 8;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    ACK      = 2'd2,
    WAIT_LOW = 2'd3
  } rcv_state_t;

endpackage

// File: rtl/uart_rcv_fifo_if.sv
// Signal bundle between the UART receiver/APB side and the receive FIFO.
// Receiver side: data_ready is a level held with rx_data/framing_error until a one-cycle data_read;
// APB side: read_enable/overflow_clear are single-cycle strobes, outputs are status/head data.
interface uart_rcv_fifo_if #(
  parameter int DATA_W = 8
);
  logic              data_ready;
  logic [DATA_W-1:0] rx_data;
  logic              framing_error;
  logic              data_read;
  logic              read_enable;
  logic              overflow_clear;
  logic [31:0]       pDataRead;
  logic              rcvEmpty;
  logic              rcvFull;
  logic              rcvOverflow;

  modport slave (
    input  data_ready, rx_data, framing_error, read_enable, overflow_clear,
    output data_read, pDataRead, rcvEmpty, rcvFull, rcvOverflow
  );

  modport master (
    output data_ready, rx_data, framing_error, read_enable, overflow_clear,
    input  data_read, pDataRead, rcvEmpty, rcvFull, rcvOverflow
  );
endinterface

// File: rtl/rcv_fifo_buffer.sv
// Circular buffer with show-ahead read data; a push into a full buffer succeeds
// only when a pop happens in the same cycle.
module rcv_fifo_buffer #(
  parameter int DEPTH = 8,
  parameter int W     = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_empty;
  logic          r_full;

  logic          w_pop_ok;
  logic          w_push_ok;
  logic [AW:0]   w_count_nxt;

  assign w_pop_ok  = i_pop && !r_empty;
  assign w_push_ok = i_push && (!r_full || w_pop_ok);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Flags are registered from the next count so they never disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_empty ? '0 : r_mem[r_rptr];
  assign o_empty = r_empty;
  assign o_full  = r_full;
  assign o_count = r_count;
endmodule

// File: rtl/uart_rcv_fifo.sv
// UART receive FIFO: captures each receiver character once, acknowledges it,
// queues {framing_error, char} and tracks a sticky overflow flag.
module uart_rcv_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_rcv_fifo_if.slave         bus,
  output rcv_state_t             o_dbg_state,
  output logic [$clog2(DEPTH):0] o_dbg_count
);
  rcv_state_t        r_state;
  logic              r_data_read;
  logic              r_overflow;

  logic              w_push;
  logic              w_pop_ok;
  logic              w_empty;
  logic              w_full;
  logic              w_overflow_evt;
  logic [DATA_W:0]   w_wdata;
  logic [DATA_W:0]   w_rdata;

  assign w_push         = (r_state == CAPTURE);
  assign w_pop_ok       = bus.read_enable && !w_empty;
  assign w_overflow_evt = w_push && w_full && !w_pop_ok;
  assign w_wdata        = {bus.framing_error, bus.rx_data};

  rcv_fifo_buffer #(
    .DEPTH (DEPTH),
    .W     (DATA_W + 1)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (bus.read_enable),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (o_dbg_count)
  );

  // data_read is raised on the CAPTURE->ACK edge, so it is high exactly while in ACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_data_read <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_data_read <= 1'b0;
      case (r_state)
        IDLE:     if (bus.data_ready) r_state <= CAPTURE;
        CAPTURE: begin
          r_state     <= ACK;
          r_data_read <= 1'b1;
        end
        ACK:      r_state <= WAIT_LOW;
        WAIT_LOW: if (!bus.data_ready) r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
      if (w_overflow_evt)          r_overflow <= 1'b1;
      else if (bus.overflow_clear) r_overflow <= 1'b0;
    end
  end

  assign bus.data_read   = r_data_read;
  assign bus.pDataRead   = {{(31 - DATA_W){1'b0}}, w_rdata};
  assign bus.rcvEmpty    = w_empty;
  assign bus.rcvFull     = w_full;
  assign bus.rcvOverflow = r_overflow;
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_uart_rcv_fifo.sv
// Directed bench for uart_rcv_fifo: a vector table of send/read/clear steps
// followed by hand-timed sequences for coincident pop/push, clear/set and reset.
module tb_uart_rcv_fifo;
  import uart_pkg::*;

  localparam logic [1:0] OP_SEND = 2'd0;
  localparam logic [1:0] OP_READ = 2'd1;
  localparam logic [1:0] OP_CLR  = 2'd2;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  ch;
    logic        fe;
    logic [31:0] exp_pd;
    logic        exp_empty;
    logic        exp_full;
    logic        exp_ovf;
    logic [3:0]  exp_count;
  } vec_t;

  logic       clk;
  logic       rst;
  rcv_state_t dbg_state;
  logic [3:0] dbg_count;

  vec_t       vecs[64];
  int         n_vecs;
  int         checks_total;
  int         checks_passed;
  logic [7:0] exp_q[$];

  uart_rcv_fifo_if #(.DATA_W(8)) bus ();

  uart_rcv_fifo #(.DEPTH(8), .DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_count (dbg_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_char(input logic [7:0] ch, input logic fe, input string tag);
    int cyc;
    bit got;
    cyc = 0;
    got = 1'b0;
    bus.rx_data       = ch;
    bus.framing_error = fe;
    bus.data_ready    = 1'b1;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (bus.data_read) got = 1'b1;
    end
    check({tag, " latency"}, got ? 32'(cyc) : 32'hFFFF_FFFF, 32'd2);
    bus.data_ready = 1'b0;
    @(negedge clk);
    check({tag, " ack_width"}, 32'(bus.data_read), 32'd0);
    @(negedge clk);
  endtask

  task automatic do_read();
    bus.read_enable = 1'b1;
    @(negedge clk);
    bus.read_enable = 1'b0;
  endtask

  task automatic do_clear();
    bus.overflow_clear = 1'b1;
    @(negedge clk);
    bus.overflow_clear = 1'b0;
  endtask

  function automatic void add(input logic [1:0] op, input logic [7:0] ch, input logic fe,
                              input logic [31:0] pd, input logic e, input logic f,
                              input logic o, input int c);
    vecs[n_vecs].op        = op;
    vecs[n_vecs].ch        = ch;
    vecs[n_vecs].fe        = fe;
    vecs[n_vecs].exp_pd    = pd;
    vecs[n_vecs].exp_empty = e;
    vecs[n_vecs].exp_full  = f;
    vecs[n_vecs].exp_ovf   = o;
    vecs[n_vecs].exp_count = 4'(c);
    n_vecs++;
  endfunction

  // ---------------- stimulus and scoreboard ----------------
  initial begin
    int pulses;
    checks_total       = 0;
    checks_passed      = 0;
    n_vecs             = 0;
    rst                = 1'b1;
    bus.data_ready     = 1'b0;
    bus.rx_data        = '0;
    bus.framing_error  = 1'b0;
    bus.read_enable    = 1'b0;
    bus.overflow_clear = 1'b0;

    add(OP_SEND, 8'h5A, 1'b0, 32'h0000_005A, 1'b0, 1'b0, 1'b0, 1);
    add(OP_READ, 8'h00, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 0);
    add(OP_SEND, 8'hC3, 1'b1, 32'h0000_01C3, 1'b0, 1'b0, 1'b0, 1);
    add(OP_READ, 8'h00, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 0);
    add(OP_READ, 8'h00, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++)
      add(OP_SEND, 8'(i), 1'b0, 32'h0, 1'b0, (i == 7), 1'b0, i + 1);
    add(OP_SEND, 8'hFF, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 8);
    for (int i = 0; i < 8; i++)
      add(OP_READ, 8'h00, 1'b0, (i < 7) ? 32'(i + 1) : 32'h0, (i == 7), 1'b0, 1'b1, 7 - i);
    add(OP_CLR, 8'h00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++)
      add(OP_SEND, 8'(8'h10 + i), 1'b0, 32'h10, 1'b0, (i == 7), 1'b0, i + 1);
    for (int i = 0; i < 8; i++)
      add(OP_READ, 8'h00, 1'b0, (i < 7) ? 32'(8'h11 + i) : 32'h0, (i == 7), 1'b0, 1'b0, 7 - i);

    @(negedge clk);
    do_reset();
    check("reset empty",     32'(bus.rcvEmpty),    32'd1);
    check("reset full",      32'(bus.rcvFull),     32'd0);
    check("reset overflow",  32'(bus.rcvOverflow), 32'd0);
    check("reset data_read", 32'(bus.data_read),   32'd0);
    check("reset pdata",     bus.pDataRead,        32'd0);
    check("reset count",     32'(dbg_count),       32'd0);
    check("reset state",     32'(dbg_state),       32'(IDLE));

    for (int i = 0; i < n_vecs; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      case (vecs[i].op)
        OP_SEND: send_char(vecs[i].ch, vecs[i].fe, tag);
        OP_READ: do_read();
        default: do_clear();
      endcase
      check({tag, " pdata"},    bus.pDataRead,        vecs[i].exp_pd);
      check({tag, " empty"},    32'(bus.rcvEmpty),    32'(vecs[i].exp_empty));
      check({tag, " full"},     32'(bus.rcvFull),     32'(vecs[i].exp_full));
      check({tag, " overflow"}, 32'(bus.rcvOverflow), 32'(vecs[i].exp_ovf));
      check({tag, " count"},    32'(dbg_count),       32'(vecs[i].exp_count));
    end

    // Full FIFO: pop lands in the CAPTURE cycle of 8'hAA.
    for (int i = 0; i < 8; i++) begin
      send_char(8'(8'h20 + i), 1'b0, "fill2x");
      if (i > 0) exp_q.push_back(8'(8'h20 + i));
    end
    exp_q.push_back(8'hAA);
    bus.rx_data    = 8'hAA;
    bus.framing_error = 1'b0;
    bus.data_ready = 1'b1;
    @(negedge clk);
    bus.read_enable = 1'b1;
    @(negedge clk);
    bus.read_enable = 1'b0;
    check("popcap data_read", 32'(bus.data_read),   32'd1);
    check("popcap overflow",  32'(bus.rcvOverflow), 32'd0);
    check("popcap full",      32'(bus.rcvFull),     32'd1);
    check("popcap count",     32'(dbg_count),       32'd8);
    bus.data_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      check("popcap order", bus.pDataRead, 32'(exp_q.pop_front()));
      do_read();
    end
    check("popcap drained", 32'(bus.rcvEmpty), 32'd1);

    // Overflow set coincides with a clear; the set must win.
    for (int i = 0; i < 8; i++) send_char(8'(8'h30 + i), 1'b0, "fill3x");
    bus.rx_data    = 8'hFF;
    bus.data_ready = 1'b1;
    @(negedge clk);
    bus.overflow_clear = 1'b1;
    @(negedge clk);
    bus.overflow_clear = 1'b0;
    check("clr_vs_set overflow", 32'(bus.rcvOverflow), 32'd1);
    check("clr_vs_set count",    32'(dbg_count),       32'd8);
    check("clr_vs_set head",     bus.pDataRead,        32'h30);
    bus.data_ready     = 1'b0;
    bus.overflow_clear = 1'b1;
    @(negedge clk);
    bus.overflow_clear = 1'b0;
    check("late clear overflow", 32'(bus.rcvOverflow), 32'd0);
    @(negedge clk);

    // Reset with a capture in flight and 3 entries stored.
    do_reset();
    for (int i = 0; i < 3; i++) send_char(8'(8'h40 + i), 1'b0, "fill4x");
    check("pre-rst count", 32'(dbg_count), 32'd3);
    bus.rx_data    = 8'h43;
    bus.data_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst ack suppressed 1", 32'(bus.data_read), 32'd0);
    @(negedge clk);
    check("rst ack suppressed 2", 32'(bus.data_read), 32'd0);
    check("rst empty",            32'(bus.rcvEmpty),  32'd1);
    check("rst pdata",            bus.pDataRead,      32'd0);
    check("rst count",            32'(dbg_count),     32'd0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.data_read) pulses++;
    end
    check("post-rst ack pulses", 32'(pulses), 32'd1);
    bus.data_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post-rst count", 32'(dbg_count),   32'd1);
    check("post-rst pdata", bus.pDataRead,    32'h43);
    do_read();
    check("post-rst empty", 32'(bus.rcvEmpty), 32'd1);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
